// File: rtl/adma_pkg.sv
// Shared types and constants for the DMA AXI write-completion path.
// Entry fields are sized for the widest supported channel/ID widths.
package adma_pkg;

  localparam int ADMA_CHN_W = 8;
  localparam int ADMA_ID_W  = 16;

  localparam logic [1:0] BRESP_OKAY   = 2'b00;
  localparam logic [1:0] BRESP_SLVERR = 2'b10;
  localparam logic [1:0] BRESP_DECERR = 2'b11;

  typedef struct packed {
    logic                  vld;
    logic [ADMA_CHN_W-1:0] chn_id;
    logic [ADMA_ID_W-1:0]  awid;
  } adma_ostd_ent_t;

  function automatic logic bresp_is_err(input logic [1:0] r);
    return (r == BRESP_SLVERR) || (r == BRESP_DECERR);
  endfunction

endpackage

// File: rtl/adma_ostd_queue.sv
// Collapsing age-ordered table of outstanding writes.
// Entry 0 is oldest; search returns the lowest matching index.
module adma_ostd_queue
  import adma_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADMA_CHN_W-1:0] push_chn,
  input  logic [ADMA_ID_W-1:0]  push_id,
  input  logic                  rm_en,
  input  logic [ADMA_ID_W-1:0]  srch_id,
  output logic                  hit,
  output logic [ADMA_CHN_W-1:0] hit_chn,
  output logic [CNT_W-1:0]      cnt
);

  adma_ostd_ent_t     ent_q [DEPTH];
  adma_ostd_ent_t     ent_d [DEPTH];
  logic [CNT_W-1:0]   cnt_q;
  logic [CNT_W-1:0]   cnt_d;
  logic [CNT_W-1:0]   idx;
  logic [CNT_W-1:0]   wr;
  logic               rm;

  assign cnt = cnt_q;

  // First-match ID search; descending scan leaves the oldest hit
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    hit_chn = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].vld && (ent_q[i].awid == srch_id)) begin
        hit     = 1'b1;
        idx     = CNT_W'(i);
        hit_chn = ent_q[i].chn_id;
      end
    end
  end

  // Collapse at the hit index first, then append behind the survivors
  always_comb begin
    ent_d = ent_q;
    rm    = rm_en && hit;
    if (rm) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (CNT_W'(i) >= idx) ent_d[i] = ent_q[i+1];
      end
      ent_d[DEPTH-1] = '0;
    end
    wr = cnt_q - CNT_W'(rm);
    if (push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == wr) begin
          ent_d[i].vld    = 1'b1;
          ent_d[i].chn_id = push_chn;
          ent_d[i].awid   = push_id;
        end
      end
    end
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(rm);
  end

  // Table and occupancy registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
    end
  end

endmodule

// File: rtl/adma_atx_cmpl.sv
// AXI write-completion tracker: B responses -> per-channel done pulses.
// Optional error pulses under ADMA_ATX_CMPL_ERR_EN.
module adma_atx_cmpl
  import adma_pkg::*;
#(
  parameter int DMA_CHN_NUM   = 4,
  parameter int MST_ID_W      = 5,
  parameter int ATX_NUM_OSTD  = (DMA_CHN_NUM > 1) ? DMA_CHN_NUM : 2,
  parameter int DMA_CHN_NUM_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1,
  parameter int OSTD_CNT_W    = $clog2(ATX_NUM_OSTD + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DMA_CHN_NUM_W-1:0] iss_chn_id,
  input  logic [MST_ID_W-1:0]      iss_awid,
  input  logic                     iss_vld,
  output logic                     iss_rdy,
  input  logic [MST_ID_W-1:0]      bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready,
  output logic                     atx_done [0:DMA_CHN_NUM-1],
  output logic                     atx_err  [0:DMA_CHN_NUM-1],
  output logic [OSTD_CNT_W-1:0]    ostd_cnt,
  output logic                     cmpl_unexp
);

  logic                  bready_q;
  logic                  bready_d;
  logic                  unexp_q;
  logic                  unexp_d;
  logic                  done_q [0:DMA_CHN_NUM-1];
  logic                  done_d [0:DMA_CHN_NUM-1];
  logic                  b_hs;
  logic                  iss_hs;
  logic                  hit;
  logic [ADMA_CHN_W-1:0] hit_chn;

  // bready_q doubles as the reset-released flag
  assign bready     = bready_q;
  assign iss_rdy    = bready_q && (ostd_cnt != OSTD_CNT_W'(ATX_NUM_OSTD));
  assign b_hs       = bvalid && bready_q;
  assign iss_hs     = iss_vld && iss_rdy;
  assign atx_done   = done_q;
  assign cmpl_unexp = unexp_q;

  adma_ostd_queue #(
    .DEPTH (ATX_NUM_OSTD),
    .CNT_W (OSTD_CNT_W)
  ) u_queue (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (iss_hs),
    .push_chn (ADMA_CHN_W'(iss_chn_id)),
    .push_id  (ADMA_ID_W'(iss_awid)),
    .rm_en    (b_hs),
    .srch_id  (ADMA_ID_W'(bid)),
    .hit      (hit),
    .hit_chn  (hit_chn),
    .cnt      (ostd_cnt)
  );

  // Decode a retiring hit into a one-hot done pulse; track misses
  always_comb begin
    bready_d = 1'b1;
    unexp_d  = unexp_q || (b_hs && !hit);
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      done_d[i] = b_hs && hit && (hit_chn == ADMA_CHN_W'(i));
    end
  end

  // Handshake ready, pulse and sticky-flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bready_q <= 1'b0;
      unexp_q  <= 1'b0;
      for (int i = 0; i < DMA_CHN_NUM; i++) done_q[i] <= 1'b0;
    end else begin
      bready_q <= bready_d;
      unexp_q  <= unexp_d;
      for (int i = 0; i < DMA_CHN_NUM; i++) done_q[i] <= done_d[i];
    end
  end

`ifdef ADMA_ATX_CMPL_ERR_EN
  logic err_q [0:DMA_CHN_NUM-1];
  logic err_d [0:DMA_CHN_NUM-1];

  assign atx_err = err_q;

  // Error pulse rides alongside the done pulse of the same retire
  always_comb begin
    for (int i = 0; i < DMA_CHN_NUM; i++) begin
      err_d[i] = done_d[i] && bresp_is_err(bresp);
    end
  end

  // Error pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DMA_CHN_NUM; i++) err_q[i] <= 1'b0;
    end else begin
      for (int i = 0; i < DMA_CHN_NUM; i++) err_q[i] <= err_d[i];
    end
  end
`else
  logic unused_bresp;

  assign unused_bresp = ^bresp;

  // Error reporting disabled: outputs held low
  always_comb begin
    for (int i = 0; i < DMA_CHN_NUM; i++) atx_err[i] = 1'b0;
  end
`endif

endmodule

// File: tb/tb_adma_atx_cmpl.sv
// Scoreboard bench for adma_atx_cmpl.
// Reference model: plain queues of outstanding {chn, id}.
module tb_adma_atx_cmpl;

  localparam int N     = 4;
  localparam int DEPTH = 4;
`ifdef ADMA_ATX_CMPL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] iss_chn_id = '0;
  logic [4:0] iss_awid = '0;
  logic       iss_vld = 1'b0;
  logic       iss_rdy;
  logic [4:0] bid = '0;
  logic [1:0] bresp = '0;
  logic       bvalid = 1'b0;
  logic       bready;
  logic       atx_done [0:N-1];
  logic       atx_err  [0:N-1];
  logic [2:0] ostd_cnt;
  logic       cmpl_unexp;

  int checks = 0;
  int errors = 0;

  int m_chn[$];
  int m_id[$];
  bit m_bready = 1'b0;
  bit m_unexp = 1'b0;
  int exp_chn[$];
  bit exp_err[$];

  adma_atx_cmpl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .iss_chn_id (iss_chn_id),
    .iss_awid   (iss_awid),
    .iss_vld    (iss_vld),
    .iss_rdy    (iss_rdy),
    .bid        (bid),
    .bresp      (bresp),
    .bvalid     (bvalid),
    .bready     (bready),
    .atx_done   (atx_done),
    .atx_err    (atx_err),
    .ostd_cnt   (ostd_cnt),
    .cmpl_unexp (cmpl_unexp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference update at the active edge, from spec-level rules
  task automatic model_step();
    bit rdy;
    bit bh;
    bit ih;
    int k;
    rdy = m_bready && (m_id.size() != DEPTH);
    bh  = bvalid && m_bready;
    ih  = iss_vld && rdy;
    if (bh) begin
      k = -1;
      for (int i = 0; i < m_id.size(); i++) begin
        if (k < 0 && m_id[i] == int'(bid)) k = i;
      end
      if (k >= 0) begin
        exp_chn.push_back(m_chn[k]);
        exp_err.push_back(ERR_EN && (bresp >= 2'd2));
        m_chn.delete(k);
        m_id.delete(k);
      end else begin
        m_unexp = 1'b1;
      end
    end
    if (ih) begin
      m_chn.push_back(int'(iss_chn_id));
      m_id.push_back(int'(iss_awid));
    end
    m_bready = 1'b1;
  endtask

  task automatic cyc(input int iv, input int ch, input int id,
                     input int bv, input int b, input int br);
    @(negedge clk);
    iss_vld    = iv[0];
    iss_chn_id = ch[1:0];
    iss_awid   = id[4:0];
    bvalid     = bv[0];
    bid        = b[4:0];
    bresp      = br[1:0];
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (m_id.size() > 0 && g < 20) begin
      cyc(0, 0, 0, 1, m_id[0], 0);
      g++;
    end
    idle(1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    iss_vld = 1'b0;
    bvalid  = 1'b0;
    m_chn.delete();
    m_id.delete();
    exp_chn.delete();
    exp_err.delete();
    m_bready = 1'b0;
    m_unexp  = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_bready = 1'b1;
  endtask

  // Monitor: compares DUT outputs against the model every cycle
  initial begin
    logic [N-1:0] dv;
    logic [N-1:0] ev;
    logic [N-1:0] xd;
    logic [N-1:0] xe;
    int c;
    forever begin
      @(negedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        dv[i] = atx_done[i];
        ev[i] = atx_err[i];
      end
      xd = '0;
      xe = '0;
      if (exp_chn.size() > 0) begin
        c = exp_chn.pop_front();
        xd[c] = 1'b1;
        if (exp_err.pop_front()) xe[c] = 1'b1;
      end
      chk("atx_done", 32'(dv), 32'(xd));
      chk("atx_err", 32'(ev), 32'(xe));
      chk("ostd_cnt", 32'(ostd_cnt), 32'(m_id.size()));
      chk("bready", 32'(bready), 32'(m_bready));
      chk("iss_rdy", 32'(iss_rdy),
          32'(m_bready && (m_id.size() != DEPTH)));
      chk("cmpl_unexp", 32'(cmpl_unexp), 32'(m_unexp));
    end
  end

  // Stimulus: directed scenarios then randomized traffic
  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    m_bready = 1'b1;
    idle(1);

    cyc(1, 2, 3, 0, 0, 0);
    cyc(1, 1, 5, 0, 0, 0);
    cyc(0, 0, 0, 1, 5, 0);
    cyc(0, 0, 0, 1, 3, 0);
    idle(1);

    cyc(1, 0, 7, 0, 0, 0);
    cyc(1, 3, 7, 0, 0, 0);
    cyc(0, 0, 0, 1, 7, 0);
    cyc(0, 0, 0, 1, 7, 0);
    idle(1);

    for (int i = 0; i < 4; i++) cyc(1, i, i + 1, 0, 0, 0);
    cyc(1, 2, 6, 1, 3, 0);
    cyc(1, 1, 8, 0, 0, 0);
    drain();

    cyc(1, 1, 2, 0, 0, 0);
    cyc(0, 0, 0, 1, 2, 2);
    cyc(1, 3, 4, 0, 0, 0);
    cyc(0, 0, 0, 1, 4, 3);
    idle(1);

    cyc(0, 0, 0, 1, 9, 0);
    idle(3);
    do_reset();
    idle(2);

    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 2, 2, 0, 0, 0);
    cyc(1, 3, 1, 1, 1, 0);
    do_reset();
    idle(2);

    for (int n = 0; n < 1500; n++) begin
      cyc(($urandom % 10) < 6, $urandom_range(0, 3),
          $urandom_range(0, 3), ($urandom % 10) < 4,
          $urandom_range(0, 4), $urandom_range(0, 3));
    end
    drain();
    do_reset();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adma_atx_cmpl.md
# adma_atx_cmpl

AXI write-completion tracker for the DMA. Sits beside the AXI transaction scheduler, which issues arbitrated AW/AR transactions tagged with a channel number. This block records each issued write transaction in age order, consumes B responses from the AXI write-response channel and returns a per-channel `atx_done` pulse, plus an optional error pulse. Its outputs drive the per-channel `atx_done` inputs of the scheduler.

## Interface
Parameters:
- `DMA_CHN_NUM`, 4: number of DMA channels.
- `MST_ID_W`, 5: AXI ID width.
- `ATX_NUM_OSTD`, `(DMA_CHN_NUM > 1) ? DMA_CHN_NUM : 2`: outstanding-table depth; must be ≥2.
- `DMA_CHN_NUM_W`, `(DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1`: derived; do not override.
- `OSTD_CNT_W`, `$clog2(ATX_NUM_OSTD+1)`: derived; do not override.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `iss_chn_id` in `DMA_CHN_NUM_W`: channel of the issued write transaction.
- `iss_awid` in `MST_ID_W`: AWID of the issued transaction.
- `iss_vld` in 1: issue valid.
- `iss_rdy` out 1: table can accept an entry.
- `bid` in `MST_ID_W`: AXI B ID.
- `bresp` in 2: AXI B response.
- `bvalid` in 1: AXI B valid.
- `bready` out 1: AXI B ready.
- `atx_done` out 1 `[0:DMA_CHN_NUM-1]`: one-cycle completion pulse per channel.
- `atx_err` out 1 `[0:DMA_CHN_NUM-1]`: one-cycle error pulse per channel.
- `ostd_cnt` out `OSTD_CNT_W`: number of valid table entries.
- `cmpl_unexp` out 1: sticky flag; a B response arrived with no matching entry.

## Operation
- The table is an age-ordered, collapsing queue. Entry 0 is the oldest. Each entry holds `{chn_id, awid}`, and occupancy is `ostd_cnt`.
- Issue: a handshake (`iss_vld && iss_rdy`) appends the entry at position `ostd_cnt`.
- Retire: on a B handshake (`bvalid && bready`), search for the lowest-index valid entry with `awid == bid`.
  - Hit: remove that entry and shift all higher entries down by one.
  - Hit: pulse `atx_done[chn_id]` on the next cycle.
- Miss: the B beat is consumed with no done pulse, and `cmpl_unexp` sets and holds until reset.
- Same-ID responses therefore retire in issue order. Different IDs may retire out of order.
- Simultaneous issue and retire in one cycle: collapse first, then append at `ostd_cnt-1`. `ostd_cnt` is unchanged.
- Full table (`ostd_cnt == ATX_NUM_OSTD`): `iss_rdy` is 0. A retire in the same cycle does not raise `iss_rdy` combinationally.
- Several channels may complete in successive cycles. At most one `atx_done` bit pulses per cycle.

## Timing
- Reset values: `iss_rdy` 0, `bready` 0, `atx_done`/`atx_err` all 0, `ostd_cnt` 0, `cmpl_unexp` 0, all table entries invalid.
- `bready` is registered. It goes to 1 on the first clock edge after reset deassertion and then stays at 1.
- `iss_rdy = rst-released && (ostd_cnt != ATX_NUM_OSTD)`. It depends on registered state only and never on `iss_vld`.
- Latency from B handshake at edge N to `atx_done` high is cycle N+1, for exactly one cycle.
- `ostd_cnt` updates on the same edge as the handshake.
- Reset asserted mid-operation clears the table and drops pulses immediately. Outstanding completions are lost; clean quiescence is the upstream's responsibility.

## Configuration
- `ADMA_ATX_CMPL_ERR_EN` defined:
  - `bresp` of `2'b10` (SLVERR) or `2'b11` (DECERR) on a matching retire pulses `atx_err[chn_id]` in the same cycle as `atx_done`.
  - `atx_done` still pulses.
- Not defined: `bresp` is ignored, `atx_err` is tied to 0, and no error logic is synthesized.

## Structure
- Shared package `adma_pkg`:
  - entry typedef `adma_ostd_ent_t` (`vld`, `chn_id`, `awid`);
  - `BRESP_OKAY`/`BRESP_SLVERR`/`BRESP_DECERR` constants.
- One sub-module: `adma_ostd_queue`. It is the collapsing age-ordered table with append, ID search (first-match priority) and remove-at-index. The top level holds the handshakes, pulse registers and sticky flag.

## Test plan
- Reset → `bready` 0 in the reset cycle and 1 one cycle after release. `iss_rdy` 1, `ostd_cnt` 0.
- Issue ch2/id 3 then ch1/id 5. B id 5 → `atx_done[1]` pulse next cycle, `ostd_cnt` 2→1. B id 3 → `atx_done[2]`, `ostd_cnt` 0.
- Issue ch0/id 7 then ch3/id 7. Two B id 7 beats → `atx_done[0]` then `atx_done[3]` (age order preserved).
- Fill 4 entries → `iss_rdy` 0. Assert `iss_vld` and a B hit in the same cycle → `ostd_cnt` 3, `iss_rdy` 1 next cycle, no entry lost.
- B id 9 with empty table → no `atx_done`, `cmpl_unexp` 1 and held until reset.
- With `ADMA_ATX_CMPL_ERR_EN`: issue ch1/id 2, B id 2 with `bresp` 2'b10 → `atx_done[1]` and `atx_err[1]` pulse together. Without the macro, `atx_err` stays 0.
